// File: rtl/e203_icb_resp_stub.sv
// ICB slave responder: queues up to DEPTH commands and answers them in order
// after LATENCY cycles. A small byte-writable scratch window backs in-window
// accesses; reads elsewhere return RD_PATTERN. Also counts completed responses.
module e203_icb_resp_stub #(
    parameter int              AW            = 32,
    parameter int              DW            = 32,
    parameter int              DEPTH         = 4,
    parameter int              LATENCY       = 1,
    parameter int              SCRATCH_WORDS = 4,
    parameter logic [AW-1:0]   BASE_ADDR     = '0,
    parameter logic [DW-1:0]   RD_PATTERN    = 32'hDEAD_BEEF,
    parameter bit              STRICT        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DW-1:0]     icb_cmd_wdata,
    input  logic [DW/8-1:0]   icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [DW-1:0]     icb_rsp_rdata,
    input  logic              cfg_err_all,
    output logic [15:0]       stat_txn_cnt,
    output logic              busy
);

    localparam int         PW       = $clog2(DEPTH);
    localparam int         SW       = $clog2(SCRATCH_WORDS);
    localparam int         IW       = (SW > 0) ? SW : 1;
    localparam int         MW       = DW / 8;
    localparam logic [3:0] DLY_INIT = 4'(LATENCY - 1);

    // One queued response; dly counts down to the cycle it may be presented.
    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
        logic [3:0]    dly;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [DW-1:0] scratch [SCRATCH_WORDS];

    logic          push;
    logic          pop;
    logic          in_win;
    logic [IW-1:0] idx;
    entry_t        new_entry;

    // Command decode and response presentation, all from registered state.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        in_win        = (icb_cmd_addr >> (SW + 2)) == (BASE_ADDR >> (SW + 2));
        idx           = IW'((icb_cmd_addr >> 2) & AW'(SCRATCH_WORDS - 1));
        new_entry.err = cfg_err_all | (STRICT & ~in_win);
        new_entry.dly = DLY_INIT;
        new_entry.rdata = '0;
        if (icb_cmd_read) begin
            new_entry.rdata = in_win ? scratch[idx] : RD_PATTERN;
        end

        busy          = (count != '0);
        icb_cmd_ready = (count < (PW + 1)'(DEPTH));
        icb_rsp_valid = busy & (q[head].dly == 4'd0);
        icb_rsp_err   = icb_rsp_valid & q[head].err;
        icb_rsp_rdata = icb_rsp_valid ? q[head].rdata : '0;

        push = icb_cmd_valid & icb_cmd_ready;
        pop  = icb_rsp_valid & icb_rsp_ready;
    end

    // Response queue: push at tail, pop at head, every entry's delay ticks down.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: the queue storage is reset too, so a reset leaves no stale response data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].dly != 4'd0) begin
                    q[i].dly <= q[i].dly - 4'd1;
                end
            end
            if (push) begin
                q[tail] <= new_entry;
                tail    <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Scratch window: byte-masked writes land at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < SCRATCH_WORDS; w++) begin
                scratch[w] <= '0;
            end
        end else if (push && !icb_cmd_read && in_win) begin
            for (int b = 0; b < MW; b++) begin
                if (icb_cmd_wmask[b]) begin
                    scratch[idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    // Completed-response counter, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_txn_cnt <= '0;
        end else if (pop && (stat_txn_cnt != 16'hFFFF)) begin
            stat_txn_cnt <= stat_txn_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_e203_icb_resp_stub.sv
// Bench for e203_icb_resp_stub: two instances (LATENCY=1/STRICT=0 and
// LATENCY=3/STRICT=1) checked against a transaction-level model that
// tracks accept times, expected data and a scratch image.
module tb_e203_icb_resp_stub;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] PAT  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic [31:0] cmd_addr    [2];
    logic        cmd_read    [2];
    logic [31:0] cmd_wdata   [2];
    logic [3:0]  cmd_wmask   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic        rsp_err     [2];
    logic [31:0] rsp_rdata   [2];
    logic        cfg_err_all [2];
    logic [15:0] txn_cnt     [2];
    logic        busy        [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        e203_icb_resp_stub #(
            .AW(32), .DW(32), .DEPTH(4), .LATENCY(g == 0 ? 1 : 3),
            .SCRATCH_WORDS(4), .BASE_ADDR(BASE), .RD_PATTERN(PAT),
            .STRICT(g == 0 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .icb_cmd_valid(cmd_valid[g]), .icb_cmd_ready(cmd_ready[g]),
            .icb_cmd_addr(cmd_addr[g]), .icb_cmd_read(cmd_read[g]),
            .icb_cmd_wdata(cmd_wdata[g]), .icb_cmd_wmask(cmd_wmask[g]),
            .icb_rsp_valid(rsp_valid[g]), .icb_rsp_ready(rsp_ready[g]),
            .icb_rsp_err(rsp_err[g]), .icb_rsp_rdata(rsp_rdata[g]),
            .cfg_err_all(cfg_err_all[g]), .stat_txn_cnt(txn_cnt[g]),
            .busy(busy[g])
        );
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } ent_t;

    ent_t        mq [2][$];
    logic [31:0] msc [2][4];
    int          mcnt [2];
    int          cyc = 0;
    logic        exp_ready [2];
    logic        exp_valid [2];
    logic        exp_busy  [2];
    logic        exp_err   [2];
    logic [31:0] exp_rdata [2];
    logic [15:0] exp_cnt   [2];

    // Per cycle: publish this cycle's expected outputs, then apply handshakes.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                for (int w = 0; w < 4; w++) msc[i][w] = '0;
                mcnt[i]      = 0;
                exp_ready[i] = 1'b1;
                exp_valid[i] = 1'b0;
                exp_busy[i]  = 1'b0;
                exp_err[i]   = 1'b0;
                exp_rdata[i] = '0;
                exp_cnt[i]   = '0;
            end else begin
                exp_ready[i] = mq[i].size() < 4;
                exp_busy[i]  = mq[i].size() != 0;
                exp_valid[i] = exp_busy[i] && ((cyc - mq[i][0].acc) >= lat(i));
                exp_err[i]   = exp_valid[i] ? mq[i][0].err : 1'b0;
                exp_rdata[i] = exp_valid[i] ? mq[i][0].rdata : 32'h0;
                exp_cnt[i]   = 16'(mcnt[i]);
                if (exp_valid[i] && rsp_ready[i]) begin
                    void'(mq[i].pop_front());
                    if (mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
                end
                if (cmd_valid[i] && exp_ready[i]) begin : accept
                    ent_t e;
                    bit   win;
                    int   idx;
                    win   = (cmd_addr[i] >> 4) == (BASE >> 4);
                    idx   = int'((cmd_addr[i] >> 2) & 32'd3);
                    e.err = cfg_err_all[i] || (i == 1 && !win);
                    e.acc = cyc;
                    if (cmd_read[i]) begin
                        e.rdata = win ? msc[i][idx] : PAT;
                    end else begin
                        e.rdata = '0;
                        if (win) begin
                            for (int b = 0; b < 4; b++)
                                if (cmd_wmask[i][b]) msc[i][idx][8*b +: 8] = cmd_wdata[i][8*b +: 8];
                        end
                    end
                    mq[i].push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i]   = 1'b0;
            cmd_read[i]    = 1'b0;
            cmd_addr[i]    = '0;
            cmd_wdata[i]   = '0;
            cmd_wmask[i]   = '0;
            cfg_err_all[i] = 1'b0;
            rsp_ready[i]   = 1'b1;
        end
    endtask

    // Present one command until accepted; returns one cycle after the accept.
    task automatic send(input int i, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input logic ea);
        int n = 0;
        cmd_valid[i] = 1'b1; cmd_read[i] = rd; cmd_addr[i] = a;
        cmd_wdata[i] = wd;   cmd_wmask[i] = m; cfg_err_all[i] = ea;
        sample();
        while (!exp_ready[i] && n < 50) begin
            next_cycle(); sample(); n++;
        end
        checks++;
        if (!exp_ready[i]) begin
            errors++;
            $display("FAIL send_timeout inst %0d addr %h not accepted in 50 cycles", i, a);
        end
        next_cycle();
        cmd_valid[i] = 1'b0; cfg_err_all[i] = 1'b0;
    endtask

    // Wait (bounded) for the next response and return it.
    task automatic get_rsp(input int i, output logic e, output logic [31:0] d);
        int n = 0;
        rsp_ready[i] = 1'b1;
        sample();
        while (rsp_valid[i] !== 1'b1 && n < 50) begin
            next_cycle(); sample(); n++;
        end
        checks++;
        if (rsp_valid[i] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout inst %0d no response in 50 cycles", i);
        end
        e = rsp_err[i];
        d = rsp_rdata[i];
        next_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        sample();
        for (int i = 0; i < 2; i++) begin
            checks += 6;
            if (rsp_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid inst %0d got %b want 0", i, rsp_valid[i]); end
            if (rsp_err[i]   !== 1'b0) begin errors++; $display("FAIL reset_rsp_err inst %0d got %b want 0", i, rsp_err[i]); end
            if (rsp_rdata[i] !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata inst %0d got %h want 0", i, rsp_rdata[i]); end
            if (txn_cnt[i]   !== 16'h0) begin errors++; $display("FAIL reset_txn_cnt inst %0d got %h want 0", i, txn_cnt[i]); end
            if (busy[i]      !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d got %b want 0", i, busy[i]); end
            if (cmd_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready inst %0d got %b want 1", i, cmd_ready[i]); end
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic_rw();
        send(0, 1'b0, BASE + 32'd4, 32'h1234_5678, 4'hF, 1'b0);
        sample();
        checks += 3;
        if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_wr_valid got %b want 1", rsp_valid[0]); end
        if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b want 0", rsp_err[0]); end
        if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL basic_wr_rdata got %h want 0", rsp_rdata[0]); end
        next_cycle();
        send(0, 1'b1, BASE + 32'd4, 32'h0, 4'h0, 1'b0);
        sample();
        checks += 3;
        if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_rd_valid got %b want 1", rsp_valid[0]); end
        if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL basic_rd_err got %b want 0", rsp_err[0]); end
        if (rsp_rdata[0] !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd_rdata got %h want 12345678", rsp_rdata[0]); end
        next_cycle();
        sample();
        checks += 2;
        if (txn_cnt[0] !== 16'd2) begin errors++; $display("FAIL basic_txn_cnt got %0d want 2", txn_cnt[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy[0]); end
        next_cycle();
    endtask

    task automatic test_mask_oow();
        logic        e;
        logic [31:0] d, wd, bm;
        logic [3:0]  m;
        send(1, 1'b0, BASE + 32'd8, 32'hAABB_CCDD, 4'b0101, 1'b0);
        get_rsp(1, e, d);
        send(1, 1'b1, BASE + 32'd8, 32'h0, 4'h0, 1'b0);
        get_rsp(1, e, d);
        checks += 2;
        if (d !== 32'h00BB_00DD) begin errors++; $display("FAIL mask_rdata got %h want 00bb00dd", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL mask_err got %b want 0", e); end
        send(1, 1'b1, BASE + 32'd16, 32'h0, 4'h0, 1'b0);
        get_rsp(1, e, d);
        checks += 2;
        if (d !== PAT) begin errors++; $display("FAIL oow_rdata got %h want deadbeef", d); end
        if (e !== 1'b1) begin errors++; $display("FAIL oow_err got %b want 1", e); end
        // random mask on a still-zero word, address offset bits must be ignored
        wd = $urandom;
        m  = 4'($urandom_range(1, 15));
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        send(1, 1'b0, BASE + 32'($urandom_range(0, 3)), wd, m, 1'b0);
        get_rsp(1, e, d);
        send(1, 1'b1, BASE + 32'd0, 32'h0, 4'h0, 1'b0);
        get_rsp(1, e, d);
        checks++;
        if (d !== (wd & bm)) begin errors++; $display("FAIL rand_mask_rdata got %h want %h", d, wd & bm); end
    endtask

    task automatic test_full_queue();
        logic        e;
        logic [31:0] d;
        logic [31:0] w     [4];
        logic [31:0] addrs [6];
        logic [31:0] xd    [6];
        logic        xe    [6];
        int n = 0;
        int k = 0;
        for (int j = 0; j < 4; j++) begin
            w[j] = $urandom;
            send(1, 1'b0, BASE + 32'(4 * j), w[j], 4'hF, 1'b0);
            get_rsp(1, e, d);
        end
        for (int j = 0; j < 4; j++) begin
            addrs[j] = BASE + 32'(4 * j); xd[j] = w[j]; xe[j] = 1'b0;
        end
        addrs[4] = BASE;          xd[4] = w[0]; xe[4] = 1'b0;
        addrs[5] = 32'h0000_2000; xd[5] = PAT;  xe[5] = 1'b1;
        rsp_ready[1] = 1'b0;
        cmd_read[1]  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cmd_valid[1] = 1'b1;
            cmd_addr[1]  = addrs[n];
            sample();
            if (c >= 4) begin
                checks++;
                if (cmd_ready[1] !== 1'b0) begin errors++; $display("FAIL full_cmd_ready cyc %0d got %b want 0", c, cmd_ready[1]); end
            end
            if (c >= 3) begin
                checks += 2;
                if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b want 1", c, rsp_valid[1]); end
                if (rsp_rdata[1] !== xd[0]) begin errors++; $display("FAIL stall_rdata cyc %0d got %h want %h", c, rsp_rdata[1], xd[0]); end
            end
            if (exp_ready[1]) n++;
            next_cycle();
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL full_accepted got %0d want 4", n); end
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            cmd_valid[1] = (n < 6);
            cmd_addr[1]  = addrs[(n < 6) ? n : 5];
            sample();
            if (c == 0) begin
                checks++;
                if (cmd_ready[1] !== 1'b0) begin errors++; $display("FAIL drain0_cmd_ready got %b want 0", cmd_ready[1]); end
            end
            if (c == 1) begin
                checks++;
                if (cmd_ready[1] !== 1'b1) begin errors++; $display("FAIL drain1_cmd_ready got %b want 1", cmd_ready[1]); end
            end
            checks++;
            if (rsp_valid[1] !== exp_valid[1]) begin errors++; $display("FAIL drain_valid cyc %0d got %b want %b", c, rsp_valid[1], exp_valid[1]); end
            if (rsp_valid[1] === 1'b1) begin
                checks += 2;
                if (rsp_rdata[1] !== xd[k]) begin errors++; $display("FAIL order_rdata #%0d got %h want %h", k, rsp_rdata[1], xd[k]); end
                if (rsp_err[1] !== xe[k]) begin errors++; $display("FAIL order_err #%0d got %b want %b", k, rsp_err[1], xe[k]); end
                k++;
            end
            if (cmd_valid[1] && exp_ready[1]) n++;
            next_cycle();
        end
        cmd_valid[1] = 1'b0;
        checks++;
        if (k !== 6) begin errors++; $display("FAIL drain_count got %0d want 6", k); end
    endtask

    task automatic test_err_inject();
        int j = $urandom_range(0, 2);
        for (int t = 0; t < 3; t++) begin
            send(0, 1'b1, BASE + 32'd4, 32'h0, 4'h0, (t == j));
            sample();
            checks += 3;
            if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL errinj_valid #%0d got %b want 1", t, rsp_valid[0]); end
            if (rsp_err[0] !== (t == j)) begin errors++; $display("FAIL errinj_err #%0d got %b want %b", t, rsp_err[0], (t == j)); end
            if (rsp_rdata[0] !== 32'h1234_5678) begin errors++; $display("FAIL errinj_rdata #%0d got %h want 12345678", t, rsp_rdata[0]); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                cmd_valid[i] = 1'($urandom_range(0, 1));
                cmd_read[i]  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0)
                    cmd_addr[i] = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
                else
                    cmd_addr[i] = $urandom;
                cmd_wdata[i]   = $urandom;
                cmd_wmask[i]   = 4'($urandom_range(0, 15));
                rsp_ready[i]   = ($urandom_range(0, 3) != 0);
                cfg_err_all[i] = ($urandom_range(0, 7) == 0);
            end
            sample();
            for (int i = 0; i < 2; i++) begin
                checks += 4;
                if (cmd_ready[i] !== exp_ready[i]) begin errors++; $display("FAIL rnd_cmd_ready inst %0d cyc %0d got %b want %b", i, c, cmd_ready[i], exp_ready[i]); end
                if (busy[i] !== exp_busy[i]) begin errors++; $display("FAIL rnd_busy inst %0d cyc %0d got %b want %b", i, c, busy[i], exp_busy[i]); end
                if (rsp_valid[i] !== exp_valid[i]) begin errors++; $display("FAIL rnd_rsp_valid inst %0d cyc %0d got %b want %b", i, c, rsp_valid[i], exp_valid[i]); end
                if (txn_cnt[i] !== exp_cnt[i]) begin errors++; $display("FAIL rnd_txn_cnt inst %0d cyc %0d got %0d want %0d", i, c, txn_cnt[i], exp_cnt[i]); end
                if (exp_valid[i]) begin
                    checks += 2;
                    if (rsp_err[i] !== exp_err[i]) begin errors++; $display("FAIL rnd_rsp_err inst %0d cyc %0d got %b want %b", i, c, rsp_err[i], exp_err[i]); end
                    if (rsp_rdata[i] !== exp_rdata[i]) begin errors++; $display("FAIL rnd_rsp_rdata inst %0d cyc %0d got %h want %h", i, c, rsp_rdata[i], exp_rdata[i]); end
                end
            end
            next_cycle();
        end
        idle_all();
        repeat (12) next_cycle();
    endtask

    task automatic test_reset_mid();
        logic        e;
        logic [31:0] d;
        rsp_ready[1] = 1'b0;
        for (int t = 0; t < 3; t++) send(1, 1'b1, BASE + 32'(4 * t), 32'h0, 4'h0, 1'b0);
        sample();
        checks++;
        if (busy[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", busy[1]); end
        next_cycle();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (rsp_valid[i] !== 1'b0) begin errors++; $display("FAIL midrst_valid inst %0d got %b want 0", i, rsp_valid[i]); end
            if (busy[i] !== 1'b0) begin errors++; $display("FAIL midrst_busy inst %0d got %b want 0", i, busy[i]); end
            if (txn_cnt[i] !== 16'h0) begin errors++; $display("FAIL midrst_txn_cnt inst %0d got %h want 0", i, txn_cnt[i]); end
        end
        sample();
        next_cycle();
        rst = 1'b0;
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL stale_rsp cyc %0d got %b want 0", c, rsp_valid[1]); end
            next_cycle();
        end
        send(1, 1'b1, BASE + 32'd8, 32'h0, 4'h0, 1'b0);
        get_rsp(1, e, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL postrst_scratch1 got %h want 0", d); end
        send(0, 1'b1, BASE + 32'd4, 32'h0, 4'h0, 1'b0);
        sample();
        checks++;
        if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL postrst_scratch0 got %h want 0", rsp_rdata[0]); end
        next_cycle();
    endtask

    task automatic test_saturation();
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b1; cmd_read[i] = 1'b1; cmd_addr[i] = BASE; rsp_ready[i] = 1'b1;
        end
        sample();
        while (!(mcnt[0] >= 65535 && mcnt[1] >= 65535) && n < 70000) begin
            next_cycle(); sample(); n++;
        end
        repeat (4) begin next_cycle(); sample(); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (txn_cnt[i] !== 16'hFFFF) begin errors++; $display("FAIL sat_txn_cnt inst %0d got %h want ffff", i, txn_cnt[i]); end
        end
        next_cycle();
        idle_all();
        repeat (8) next_cycle();
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_rw();
        test_mask_oow();
        test_full_queue();
        test_err_inject();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
